// File: rtl/sq_idx_alloc.sv
// Store-queue index allocator: hands out {flipped,idx} entries in order, retires at head,
// rolls tail back on squash. Optional stall counter enabled by defining SQ_STALL_STAT_EN.
`ifndef SQSIZE
`define SQSIZE 64
`endif

module sq_idx_alloc #(
    parameter int unsigned SIZE         = `SQSIZE,
    parameter int unsigned ALLOC_WIDTH  = 4,
    parameter int unsigned COMMIT_WIDTH = 2,
    localparam int unsigned IW          = $clog2(SIZE),
    localparam int unsigned PW          = IW + 1,
    localparam int unsigned CW          = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ALLOC_WIDTH-1:0]           i_alloc_req,
    output logic                             o_alloc_rdy,
    output logic [ALLOC_WIDTH-1:0][PW-1:0]   o_alloc_idx,
    input  logic [CW-1:0]                    i_commit_cnt,
    input  logic                             i_squash,
    input  logic [PW-1:0]                    i_squash_idx,
    output logic [PW-1:0]                    o_head,
    output logic [PW-1:0]                    o_tail,
    output logic [PW-1:0]                    o_count,
    output logic                             o_empty,
`ifdef SQ_STALL_STAT_EN
    output logic [31:0]                      o_stall_cycles,
`endif
    output logic                             o_full
);

    localparam int unsigned PCW = $clog2(ALLOC_WIDTH + 1);

    logic [PW-1:0]                  r_head;
    logic [PW-1:0]                  r_tail;
    logic [PW-1:0]                  w_head_d;
    logic [PW-1:0]                  w_tail_d;
    logic [PW-1:0]                  w_count;
    logic [PW-1:0]                  w_free;
    logic [PW-1:0]                  w_commit;
    logic [PCW-1:0]                 w_alloc_cnt;
    logic [ALLOC_WIDTH-1:0][PW-1:0] w_alloc_idx;
    logic                           w_rdy;
    logic                           w_fire;

    // Pointers carry the wrap bit as their MSB, so plain modular add/sub handles the flip.
    always_comb begin
        logic [PCW-1:0] v_pc;
        v_pc        = '0;
        w_alloc_idx = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            w_alloc_idx[i] = r_tail + PW'(v_pc);
            v_pc           = v_pc + PCW'(i_alloc_req[i]);
        end
        w_alloc_cnt = v_pc;
    end

    always_comb begin
        w_count  = r_tail - r_head;
        w_free   = PW'(SIZE) - w_count;
        w_rdy    = (w_free >= PW'(w_alloc_cnt));
        w_fire   = (|i_alloc_req) && w_rdy && !i_squash;
        w_commit = (PW'(i_commit_cnt) > w_count) ? w_count : PW'(i_commit_cnt);
        w_head_d = r_head + w_commit;
        w_tail_d = r_tail;
        if (i_squash) begin
            w_tail_d = i_squash_idx;
        end else if (w_fire) begin
            w_tail_d = r_tail + PW'(w_alloc_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= w_head_d;
            r_tail <= w_tail_d;
        end
    end

`ifdef SQ_STALL_STAT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if ((|i_alloc_req) && !w_rdy && !i_squash && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall;
`endif

    assign o_alloc_rdy = w_rdy;
    assign o_alloc_idx = w_alloc_idx;
    assign o_head      = r_head;
    assign o_tail      = r_tail;
    assign o_count     = w_count;
    assign o_empty     = (w_count == '0);
    assign o_full      = (r_tail[IW-1:0] == r_head[IW-1:0]) && (r_tail[IW] != r_head[IW]);

endmodule

// File: tb/tb_sq_idx_alloc.sv
// Directed bench for sq_idx_alloc (SIZE=64, ALLOC_WIDTH=4, COMMIT_WIDTH=2).
module tb_sq_idx_alloc;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic             rdy;
    logic [3:0][6:0]  aidx;
    logic [1:0]       commit;
    logic             squash;
    logic [6:0]       squash_idx;
    logic [6:0]       head;
    logic [6:0]       tail;
    logic [6:0]       count;
    logic             empty;
    logic             full;
`ifdef SQ_STALL_STAT_EN
    logic [31:0]      stall;
`endif

    int checks = 0;
    int errors = 0;

    sq_idx_alloc dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_alloc_req   (req),
        .o_alloc_rdy   (rdy),
        .o_alloc_idx   (aidx),
        .i_commit_cnt  (commit),
        .i_squash      (squash),
        .i_squash_idx  (squash_idx),
        .o_head        (head),
        .o_tail        (tail),
        .o_count       (count),
        .o_empty       (empty),
`ifdef SQ_STALL_STAT_EN
        .o_stall_cycles(stall),
`endif
        .o_full        (full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req    = '0;
        commit = '0;
        squash = 1'b0;
        rst_n  = 1'b0;
        #1;
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        commit     = '0;
        squash     = 1'b0;
        squash_idx = '0;
        #2;
        chk("rst_head", 32'(head), 32'h00);
        chk("rst_tail", 32'(tail), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", {29'd0, empty, full, rdy}, 32'b101);
        rst_n = 1'b1;

        // Async reset mid-cycle, no clock edge
        req = 4'hF;
        tick();
        chk("pre_rst_tail", 32'(tail), 32'h04);
        rst_n = 1'b0;
        #1;
        chk("midrst_tail", 32'(tail), 32'h00);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_flags", {29'd0, empty, full, rdy}, 32'b101);
        req   = '0;
        rst_n = 1'b1;

        // Fill
        req = 4'hF;
        #1;
        chk("fill_idx0", 32'(aidx), {4'd0, 7'h03, 7'h02, 7'h01, 7'h00});
        repeat (16) tick();
        chk("fill_tail", 32'(tail), 32'h40);
        chk("fill_count", 32'(count), 32'd64);
        chk("fill_flags", {29'd0, empty, full, rdy}, 32'b010);
        tick();
        chk("full_tail_hold", 32'(tail), 32'h40);
`ifdef SQ_STALL_STAT_EN
        chk("stall_cnt", stall, 32'd1);
`endif
        req = '0;
        #1;
        chk("full_req0_rdy", 32'(rdy), 32'd1);

        // Wrap: move head=tail to {0,62}
        do_reset();
        req = 4'hF;
        repeat (15) tick();
        req = 4'b0011;
        tick();
        req    = '0;
        commit = 2'd2;
        repeat (31) tick();
        chk("drain_head", 32'(head), 32'h3E);
        chk("drain_empty", 32'(empty), 32'd1);
        tick();
        chk("overcommit_head", 32'(head), 32'h3E);
        commit = '0;
        req    = 4'hF;
        #1;
        chk("wrap_idx", 32'(aidx), {4'd0, 7'h41, 7'h40, 7'h3F, 7'h3E});
        tick();
        chk("wrap_tail", 32'(tail), 32'h42);
        chk("wrap_count", 32'(count), 32'd4);

        // Compaction with commit
        req = 4'b0011;
        repeat (3) tick();
        chk("cmp_count0", 32'(count), 32'd10);
        req = 4'b1010;
        #1;
        chk("cmp_1010", {18'd0, aidx[3], aidx[1]}, {18'd0, 7'h49, 7'h48});
        req    = 4'b0101;
        commit = 2'd2;
        #1;
        chk("cmp_0101", {18'd0, aidx[2], aidx[0]}, {18'd0, 7'h49, 7'h48});
        chk("cmp_rdy", 32'(rdy), 32'd1);
        tick();
        chk("cmp_count1", 32'(count), 32'd10);
        chk("cmp_tail", 32'(tail), 32'h4A);
        chk("cmp_head", 32'(head), 32'h40);

        // No credit for same-cycle commit
        commit = '0;
        req    = 4'hF;
        repeat (13) tick();
        req = 4'b0001;
        tick();
        chk("nc_count63", 32'(count), 32'd63);
        req    = 4'b0011;
        commit = 2'd2;
        #1;
        chk("nc_rdy", 32'(rdy), 32'd0);
        tick();
        chk("nc_tail", 32'(tail), 32'h7F);
        chk("nc_head", 32'(head), 32'h42);
        chk("nc_count", 32'(count), 32'd61);

        // Squash with commit and dropped alloc
        do_reset();
        req = 4'hF;
        repeat (5) tick();
        req    = '0;
        commit = 2'd2;
        repeat (2) tick();
        commit = 2'd1;
        tick();
        chk("sq_pre", {18'd0, head, tail}, {18'd0, 7'h05, 7'h14});
        squash     = 1'b1;
        squash_idx = 7'h09;
        req        = 4'hF;
        commit     = 2'd1;
        tick();
        chk("sq_tail", 32'(tail), 32'h09);
        chk("sq_head", 32'(head), 32'h06);
        chk("sq_count", 32'(count), 32'd3);
        squash = 1'b0;
        req    = '0;
        commit = 2'd2;
        tick();
        chk("clamp_count1", 32'(count), 32'd1);
        tick();
        chk("clamp_head", 32'(head), 32'h09);
        chk("clamp_empty", 32'(empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
